// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle CPU control state machine
//
// Purpose: sequences fetch, decode, execute, memory and write-back for a
// small MIPS-like instruction set and drives the datapath control lines.
//
// Ports:
//   clk, RST (sync, active-low)
//   opcode      - instruction opcode, latched in IF
//   zero        - ALU zero flag (branch decision)
//   imem_ready  - instruction fetch complete
//   dmem_ready  - data access complete
//   PCWre, PCSrc, IRWre, ALUSrcB, ExtSel, ALUOp, RegWre, RegOut,
//   WrRegData, ALUM2Reg, DataMemEn, DataMemRW - datapath controls
//   state       - current state (debug)
//   halted      - in HALT state
//   illegal     - sticky, undefined opcode decoded
module mc_control_fsm #(
  parameter int ALUOP_W   = 3,
  parameter bit HANDSHAKE = 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               ALUSrcB,
  output logic [1:0]         ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegWre,
  output logic [1:0]         RegOut,
  output logic               WrRegData,
  output logic               ALUM2Reg,
  output logic               DataMemEn,
  output logic               DataMemRW,
  output logic [3:0]         state,
  output logic               halted,
  output logic               illegal
);

  localparam logic [3:0] S_IF    = 4'd0;
  localparam logic [3:0] S_ID    = 4'd1;
  localparam logic [3:0] S_EXE_R = 4'd2;
  localparam logic [3:0] S_WB_R  = 4'd3;
  localparam logic [3:0] S_EXE_B = 4'd4;
  localparam logic [3:0] S_EXE_M = 4'd5;
  localparam logic [3:0] S_MEM   = 4'd6;
  localparam logic [3:0] S_WB_L  = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [5:0] op_q;
  logic       i_rdy;
  logic       d_rdy;

  // With the handshake disabled the memories are assumed single-cycle.
  assign i_rdy = HANDSHAKE ? imem_ready : 1'b1;
  assign d_rdy = HANDSHAKE ? dmem_ready : 1'b1;

  // ALU instruction table, decoded from the latched opcode.
  logic       is_alu;
  logic [2:0] alu_op;
  logic       alu_srcb;
  logic [1:0] alu_ext;
  logic [1:0] alu_regout;

  always_comb begin
    is_alu     = 1'b1;
    alu_op     = 3'b000;
    alu_srcb   = 1'b0;
    alu_ext    = 2'b00;
    alu_regout = 2'b10;
    case (op_q)
      OP_ADD:  alu_op = 3'b000;
      OP_SUB:  alu_op = 3'b001;
      OP_ADDI: begin alu_op = 3'b000; alu_srcb = 1'b1; alu_ext = 2'b10; alu_regout = 2'b01; end
      OP_OR:   alu_op = 3'b101;
      OP_AND:  alu_op = 3'b110;
      OP_ORI:  begin alu_op = 3'b101; alu_srcb = 1'b1; alu_ext = 2'b01; alu_regout = 2'b01; end
      OP_SLL:  begin alu_op = 3'b100; alu_srcb = 1'b1; end
      OP_MOVE: alu_op = 3'b000;
      OP_SLT:  alu_op = 3'b010;
      default: begin is_alu = 1'b0; alu_regout = 2'b00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state   <= S_IF;
      op_q    <= 6'd0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (i_rdy) begin
            op_q  <= opcode;
            state <= S_ID;
          end
        end
        S_ID: begin
          if (is_alu) begin
            state <= S_EXE_R;
          end else begin
            case (op_q)
              OP_BEQ:              state <= S_EXE_B;
              OP_SW, OP_LW:        state <= S_EXE_M;
              OP_J, OP_JR, OP_JAL: state <= S_IF;
              OP_HALT:             state <= S_HALT;
              default: begin
                // Undefined opcode: flag it and retire as a no-op.
                illegal <= 1'b1;
                state   <= S_IF;
              end
            endcase
          end
        end
        S_EXE_R: state <= S_WB_R;
        S_WB_R:  state <= S_IF;
        S_EXE_B: state <= S_IF;
        S_EXE_M: state <= S_MEM;
        S_MEM: begin
          if (d_rdy) state <= (op_q == OP_LW) ? S_WB_L : S_IF;
        end
        S_WB_L:  state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  assign halted = (state == S_HALT);

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 2'b00;
    ALUOp     = '0;
    RegWre    = 1'b0;
    RegOut    = 2'b00;
    WrRegData = 1'b0;
    ALUM2Reg  = 1'b0;
    DataMemEn = 1'b0;
    DataMemRW = 1'b0;
    case (state)
      S_IF: begin
        IRWre = i_rdy;
        PCWre = i_rdy;
      end
      S_ID: begin
        case (op_q)
          OP_J:  begin PCWre = 1'b1; PCSrc = 2'b11; end
          OP_JR: begin PCWre = 1'b1; PCSrc = 2'b10; end
          OP_JAL: begin
            // Link to $31 with PC+4 as the write data.
            PCWre  = 1'b1;
            PCSrc  = 2'b11;
            RegWre = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXE_R: begin
        ALUOp   = ALUOP_W'(alu_op);
        ALUSrcB = alu_srcb;
        ExtSel  = alu_ext;
      end
      S_WB_R: begin
        ALUOp     = ALUOP_W'(alu_op);
        ALUSrcB   = alu_srcb;
        ExtSel    = alu_ext;
        RegWre    = 1'b1;
        WrRegData = 1'b1;
        RegOut    = alu_regout;
      end
      S_EXE_B: begin
        ExtSel = 2'b10;
        ALUOp  = ALUOP_W'(3'b111);
        PCWre  = zero;
        PCSrc  = {1'b0, zero};
      end
      S_EXE_M: begin
        ALUSrcB = 1'b1;
        ExtSel  = 2'b10;
      end
      S_MEM: begin
        ALUSrcB   = 1'b1;
        ExtSel    = 2'b10;
        DataMemEn = 1'b1;
        DataMemRW = (op_q == OP_SW);
      end
      S_WB_L: begin
        RegWre    = 1'b1;
        ALUM2Reg  = 1'b1;
        WrRegData = 1'b1;
        RegOut    = 2'b01;
      end
      default: ;
    endcase
    // Nothing may be written while reset is held, whatever the state.
    if (!RST) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      DataMemEn = 1'b0;
      DataMemRW = 1'b0;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, ALU operation code width (>=3); 3-bit codes zero-extended.
REQ-002 SHALL have parameter HANDSHAKE, default 1; 0 = imem_ready/dmem_ready ignored, treated as 1.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-low
- opcode  in  6  instruction opcode from instruction register
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete
- PCWre  out  1  PC write enable
- PCSrc  out  2  00 PC+4, 01 branch, 10 jr, 11 jump
- IRWre  out  1  instruction register load
- ALUSrcB  out  1  0 rt, 1 ext imm
- ExtSel  out  2  00 shamt, 01 zero-ext, 10 sign-ext
- ALUOp  out  ALUOP_W  ALU operation
- RegWre  out  1  register file write
- RegOut  out  2  00 $31, 01 rt, 10 rd
- WrRegData  out  1  0 PC+4, 1 ALU/mem
- ALUM2Reg  out  1  1 write-back from data memory
- DataMemEn  out  1  data memory access request
- DataMemRW  out  1  1 write, 0 read; valid while DataMemEn=1
- state  out  4  current state, for debug
- halted  out  1  in HALT state
- illegal  out  1  sticky, undefined opcode seen

Function
REQ-004 States (encoding): IF 0, ID 1, EXE_R 2, WB_R 3, EXE_B 4, EXE_M 5, MEM 6, WB_L 7, HALT 8.
REQ-005 Outputs SHALL be Moore, decoded from state and the opcode latched in IF (op_q); all unlisted outputs 0, never X/Z.
REQ-006 IF: IRWre=PCWre=imem_ready, PCSrc=00; on imem_ready, latch opcode into op_q, go to ID; else stay IF.
REQ-007 ID dispatch on op_q: R/I ALU -> EXE_R; beq -> EXE_B; lw/sw -> EXE_M; j, jr, jal -> IF; halt -> HALT; other -> IF with illegal set.
REQ-008 ID, jump ops: PCWre=1; PCSrc=11 (j, jal), 10 (jr); jal also RegWre=1, WrRegData=0, RegOut=00.
REQ-009 ALU table (opcode: ALUOp, ALUSrcB, ExtSel, RegOut): add 000000: 000,0,00,10; sub 000001: 001,0,00,10; addi 000010: 000,1,10,01; or 010000: 101,0,00,10; and 010001: 110,0,00,10; ori 010010: 101,1,01,01; sll 011000: 100,1,00,10; move 100000: 000,0,00,10; slt 100111: 010,0,00,10.
REQ-010 EXE_R: ALUOp, ALUSrcB, ExtSel per table -> WB_R; WB_R: same plus RegWre=1, WrRegData=1, RegOut per table -> IF.
REQ-011 EXE_B (beq 110100): ALUSrcB=0, ExtSel=10, ALUOp=111, PCSrc=zero?01:00, PCWre=zero -> IF.
REQ-012 EXE_M (sw 110000, lw 110001): ALUSrcB=1, ExtSel=10, ALUOp=000 -> MEM.
REQ-013 MEM: EXE_M controls held, DataMemEn=1, DataMemRW=1 for sw, 0 for lw; stay until dmem_ready; then sw -> IF, lw -> WB_L.
REQ-014 WB_L: RegWre=1, ALUM2Reg=1, WrRegData=1, RegOut=01 -> IF.
REQ-015 HALT: halted=1, all enables 0; exit only via RST.
REQ-016 Cycle counts with ready=1: R/I 4, beq 3, sw 4, lw 5, jumps 2.
REQ-017 Each ready wait cycle SHALL add exactly one cycle; no output toggles while waiting.
REQ-018 illegal SHALL stay 1 until reset; the illegal opcode executes as a 2-cycle no-op.

Reset
REQ-019 RST=0 at rising edge: state=IF, op_q=0, halted=0, illegal=0; takes priority in any state, including a MEM wait or HALT.
REQ-020 While RST=0, all write enables and DataMemEn SHALL be 0; fetch starts on the first edge with RST=1.

Verification
REQ-021 add (000000), ready=1 -> states IF,ID,EXE_R,WB_R; RegWre=1 only in WB_R with RegOut=10, ALUOp=000.
REQ-022 lw, dmem_ready low for 3 cycles in MEM -> DataMemEn=1, DataMemRW=0 for 4 cycles; WB_L RegWre=1, ALUM2Reg=1.
REQ-023 beq, zero=1 -> EXE_B PCWre=1, PCSrc=01; repeat with zero=0 -> PCWre=0, PCSrc=00.
REQ-024 jal -> ID PCWre=1, PCSrc=11, RegWre=1, RegOut=00, WrRegData=0; next state IF.
REQ-025 opcode 101010 -> illegal=1, state returns to IF, stays 1 across later instructions; halt 111111 -> halted=1 held; RST=0 one edge clears both.
REQ-026 RST=0 during sw MEM wait -> next state IF, DataMemEn=0; HANDSHAKE=0 with readys held 0 -> sw completes in 4 cycles.
